// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: NREQ requesters share one resource, grant locked until the holder releases.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter #(
  parameter int NREQ     = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              valid_q;
  logic              found;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic              timeout_d;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q;
`endif

  // First set request scanning upward from ptr with wrap; the last holder sits at the back.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          idx_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      BUSY: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = idx_q + IDX_W'(1);
        end
`ifdef ARB_TIMEOUT_EN
        // hold_q counts completed grant cycles minus one, so release lands after MAX_HOLD visible cycles.
        else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          state_d   = IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // 4-to-16 decode of the next index, gated by the next state.
  for (genvar g = 0; g < NREQ; g++) begin : g_dec
    assign grant_d[g] = (state_d == BUSY) && (idx_d == IDX_W'(g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      valid_q <= (state_d == BUSY);
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_d;
  assign timeout        = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: driver queues expected grants, a negedge monitor checks them.
module tb_rr_grant_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int len;   // expected visible grant cycles, 0 = not checked
    bit to;    // release is a forced timeout
  } exp_t;

  exp_t q[$];

  rr_grant_arbiter #(.NREQ(16), .IDX_W(4), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_rise();
    int n = 0;
    while (grant_valid && n < 200) begin @(posedge clk); #1; n++; end
    while (!grant_valid && n < 400) begin @(posedge clk); #1; n++; end
    if (!grant_valid) begin
      checks++; errors++;
      $display("FAIL wait_grant: no grant within bound (t=%0t)", $time);
    end
  endtask

  // Expect grant to idx for len cycles; holder's drop applied via drop_req, then after_req next cycle.
  task automatic grant_cycle(input int idx, input int len, input logic [15:0] drop_req,
                             input logic [15:0] after_req);
    exp_t e;
    e.idx = idx; e.len = len; e.to = 1'b0;
    q.push_back(e);
    wait_rise();
    repeat (len - 1) begin @(posedge clk); #1; end
    req = drop_req;
    @(posedge clk); #1;
    req = after_req;
  endtask

  // Monitor
  initial begin
    logic        prev_v = 1'b0;
    logic [15:0] prev_g = '0;
    int          run = 0;
    exp_t        cur;
    cur.idx = 0; cur.len = 0; cur.to = 1'b0;
    forever begin
      @(negedge clk);
      chk("valid_vs_grant", {31'd0, grant_valid}, {31'd0, |grant});
      chk("grant_decode", {16'd0, grant}, grant_valid ? (32'd1 << grant_idx) : 32'd0);
      chk("timeout", {31'd0, timeout}, {31'd0, prev_v && !grant_valid && cur.to});
      if (grant_valid && !prev_v) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: idx %0d with empty queue", grant_idx);
          cur.idx = 0; cur.len = 0; cur.to = 1'b0;
        end else begin
          cur = q.pop_front();
          chk("grant_idx", {28'd0, grant_idx}, cur.idx);
        end
        run = 1;
      end else if (grant_valid) begin
        chk("grant_held", {16'd0, grant}, {16'd0, prev_g});
        run++;
      end else if (prev_v && cur.len != 0) begin
        chk("grant_len", run, cur.len);
      end
      prev_v = grant_valid;
      prev_g = grant;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] m;
    exp_t e;
    // Reset with all requests asserted
    rst_n = 1'b0;
    req   = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {16'd0, grant}, 0);
    chk("rst_valid", {31'd0, grant_valid}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);
    chk("rst_idx", {28'd0, grant_idx}, 0);
    req = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester, held 3 cycles
    req = 16'h0010;
    grant_cycle(4, 3, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk); #1;

    // Rotation from ptr 0: each holder releases in its first grant cycle
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      m = 16'hFFFF;
      m[k % 16] = 1'b0;
      grant_cycle(k % 16, 1, m, (k == 16) ? 16'h0000 : 16'hFFFF);
    end
    repeat (2) @(posedge clk); #1;

    // Wrap: 14 -> 15 -> 0
    req = 16'h4000;
    grant_cycle(14, 1, 16'h0000, 16'h8001);
    grant_cycle(15, 2, 16'h0001, 16'h0001);
    grant_cycle(0, 1, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset while idx 7 holds
    e.idx = 7; e.len = 0; e.to = 1'b0;
    q.push_back(e);
    req = 16'h0080;
    wait_rise();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", {16'd0, grant}, 0);
    chk("async_rst_valid", {31'd0, grant_valid}, 0);
    req = 16'h0081;
    @(posedge clk); #1;
    rst_n = 1'b1;
    grant_cycle(0, 2, 16'h0080, 16'h0080);
    grant_cycle(7, 1, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk); #1;

    // Long hold with req 0005
    req = 16'h0005;
`ifdef ARB_TIMEOUT_EN
    e.idx = 0; e.len = 8; e.to = 1'b1;
    q.push_back(e);
    wait_rise();
    grant_cycle(2, 1, 16'h0000, 16'h0000);
`else
    grant_cycle(0, 120, 16'h0004, 16'h0004);
    grant_cycle(2, 1, 16'h0000, 16'h0000);
`endif
    repeat (4) @(posedge clk); #1;

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
